wless_tx_scheduler: RTL and testbench
=====================================

# wless_tx_scheduler

Sequences wireless transmission from the 512-byte MCU receive buffer into the node UART TX FIFO. Waits until a full packet has accumulated or the MCU link has been quiet long enough, then moves one packet byte-by-byte under FIFO back-pressure. It waits for the node UART to finish sending before the next packet. It sits between the MCU-side buffer and `uart_to_node`, drives the WTRANS state bit and the state half of AUX.

## Interface
Parameters:
- `DATA_WIDTH`, 8, byte width
- `COUNT_WIDTH`, 10, width of buffer occupancy count (0..512)
- `PACKET_SIZE`, 58, bytes per wireless packet; full-packet trigger threshold
- `END_WAITING_SEND_WLESS_DATA`, 31250, quiet-time cycles before a partial packet is sent
- `TIMER_WIDTH`, 15, quiet-timer width; must hold `END_WAITING_SEND_WLESS_DATA`

Ports:
- `internal_clk`  in  1  block clock
- `rst_n`  in  1  reset, synchronous, active-low
- `enable`  in  1  current mode permits wireless transmit
- `buf_count`  in  COUNT_WIDTH  bytes currently held in buffer
- `buf_data`  in  DATA_WIDTH  head byte of buffer (first-word-fall-through, valid when `buf_count`≠0)
- `buf_rd`  out  1  one-cycle pop of buffer head
- `data_to_uart_node`  out  DATA_WIDTH  byte written to node TX FIFO
- `TX_use_node`  out  1  one-cycle write strobe to node TX FIFO
- `TX_flag_node`  in  1  node TX FIFO full
- `TX_complete_node`  in  1  node TX FIFO empty and shifter idle
- `wtrans_active`  out  1  scheduler in LOAD or DRAIN (WTRANS state bit)
- `aux_n`  out  1  1 = idle; 0 = data pending or being sent
- `pkt_sent`  out  16  count of completed packets

## Operation
- States: IDLE, WAIT, LOAD, DRAIN.
- IDLE: if `enable` and `buf_count`≠0, go to WAIT and clear the quiet timer.
- WAIT:
  - `buf_count`≥PACKET_SIZE: latch `remaining`=PACKET_SIZE, go to LOAD.
  - Else if the timer equals END_WAITING_SEND_WLESS_DATA−1: latch `remaining`=`buf_count`, go to LOAD.
  - The timer clears on any cycle where `buf_count` differs from its previous-cycle value. Otherwise it increments and saturates.
  - `enable`=0: go to IDLE. Buffer contents are untouched.
- LOAD:
  - Alternates issue/gap cycles.
  - Issue cycle with `TX_flag_node`=0 and `remaining`≠0: assert `buf_rd` and `TX_use_node`, register `data_to_uart_node`=`buf_data`, decrement `remaining`. The next cycle is a mandatory gap.
  - `TX_flag_node`=1: no write; retry on the next cycle.
  - `remaining`=0: go to DRAIN.
- DRAIN:
  - Waits at least 2 cycles after the last write, then for `TX_complete_node`=1.
  - On completion, increment `pkt_sent` (wraps at 2^16).
  - Then go to WAIT if `enable` and `buf_count`≠0, else go to IDLE.
- `enable` dropping in LOAD or DRAIN does not truncate the packet; the packet always completes.
- `buf_count`=0 in LOAD with `remaining`≠0 is a protocol error. Go to DRAIN without popping.
- Outputs:
  - `wtrans_active` = state∈{LOAD, DRAIN}.
  - `aux_n` = state==IDLE.
  - Both are registered.

## Timing
- Reset (`rst_n`=0 at an `internal_clk` edge): state IDLE.
  - `buf_rd`=0, `TX_use_node`=0, `data_to_uart_node`=0.
  - `wtrans_active`=0, `aux_n`=1, `pkt_sent`=0, timer=0, `remaining`=0.
  - Reset mid-LOAD abandons the packet immediately; already-popped bytes are not restored.
- `buf_rd` and `TX_use_node` are asserted in the same cycle, never longer than 1 cycle, and never on consecutive cycles.
- Throughput: at most 1 byte per 2 cycles. PACKET_SIZE bytes with no back-pressure take 2·PACKET_SIZE−1 cycles from first to last strobe.
- WAIT→LOAD: 1 cycle after the trigger condition. First strobe is on the LOAD entry cycle +1.
- Quiet timeout: a partial packet starts exactly END_WAITING_SEND_WLESS_DATA cycles after the last `buf_count` change.
- Full-packet and timeout in the same cycle: full-packet wins (`remaining`=PACKET_SIZE).

## Structure
- Shared package `rf_transceiver_pkg` holds:
  - the state encoding `wtx_state_t` (IDLE=0, WAIT=1, LOAD=2, DRAIN=3);
  - default `PACKET_SIZE` and `END_WAITING_SEND_WLESS_DATA` constants, reused by `controller_RF_transceiver`.
- One sub-module, `wless_idle_timer`: clear/increment/saturate counter with a `done` compare output.

## Test plan
- Write 58 bytes 0x00..0x39, `enable`=1, FIFO never full → 58 strobes spaced 2 cycles, data in order; after `TX_complete_node`, `pkt_sent`=1, `aux_n`=1.
- Write 5 bytes then stop → no strobe for 31249 cycles; LOAD entered at exactly 31250 quiet cycles; 5 bytes sent, `remaining` reaches 0.
- 130 bytes buffered → packets of 58, 58, then 14 after timeout; `pkt_sent`=3; no strobe issued while DRAIN is waiting on `TX_complete_node`.
- Hold `TX_flag_node`=1 for 20 cycles mid-packet → no `buf_rd`/`TX_use_node` during the stall; resumes with the next byte, none lost or duplicated.
- Drop `enable` after byte 10 of a 58-byte packet → remaining 48 still sent, then IDLE. Drop `enable` in WAIT → IDLE, no pop.
- Assert `rst_n`=0 mid-LOAD → next cycle all outputs at their reset values, state IDLE, `pkt_sent`=0.

Source files
------------

// File: rtl/rf_transceiver_pkg.sv
// Shared definitions for the RF transceiver control path: scheduler state
// encoding and default packet/quiet-time constants.
package rf_transceiver_pkg;

   typedef enum logic [1:0] {
      WTX_IDLE  = 2'd0,
      WTX_WAIT  = 2'd1,
      WTX_LOAD  = 2'd2,
      WTX_DRAIN = 2'd3
   } wtx_state_t;

   localparam int unsigned PACKET_SIZE_DEF                 = 58;
   localparam int unsigned END_WAITING_SEND_WLESS_DATA_DEF = 31250;

endpackage

// File: rtl/wless_idle_timer.sv
// Quiet-time counter: clears on request, otherwise counts up and saturates.
// done flags the cycle on which the count sits at DONE_VALUE.
module wless_idle_timer #(
   parameter int          TIMER_WIDTH = 15,
   parameter int unsigned DONE_VALUE  = 31249
) (
   input  logic internal_clk,
   input  logic rst_n,
   input  logic clear,
   output logic done
);

   logic [TIMER_WIDTH-1:0] count;

   always_ff @(posedge internal_clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count != {TIMER_WIDTH{1'b1}}) begin
         count <= count + 1'b1;
      end
   end

   assign done = (count == TIMER_WIDTH'(DONE_VALUE));

endmodule

// File: rtl/wless_tx_scheduler.sv
// Moves one wireless packet at a time from the MCU receive buffer into the
// node UART TX FIFO, triggered by a full packet or by link quiet time.
//
// state | meaning
// IDLE  | nothing pending or transmit not enabled
// WAIT  | data buffered; waiting for a full packet or the quiet timeout
// LOAD  | popping bytes into the node TX FIFO, one per issue/gap pair
// DRAIN | packet loaded; waiting for the node UART to finish sending
module wless_tx_scheduler
   import rf_transceiver_pkg::*;
#(
   parameter int DATA_WIDTH                  = 8,
   parameter int COUNT_WIDTH                 = 10,
   parameter int PACKET_SIZE                 = PACKET_SIZE_DEF,
   parameter int END_WAITING_SEND_WLESS_DATA = END_WAITING_SEND_WLESS_DATA_DEF,
   parameter int TIMER_WIDTH                 = 15
) (
   input  logic                   internal_clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [COUNT_WIDTH-1:0] buf_count,
   input  logic [DATA_WIDTH-1:0]  buf_data,
   output logic                   buf_rd,
   output logic [DATA_WIDTH-1:0]  data_to_uart_node,
   output logic                   TX_use_node,
   input  logic                   TX_flag_node,
   input  logic                   TX_complete_node,
   output logic                   wtrans_active,
   output logic                   aux_n,
   output logic [15:0]            pkt_sent
);

   localparam logic [COUNT_WIDTH-1:0] PKT_LEN = COUNT_WIDTH'(PACKET_SIZE);

   wtx_state_t             state;
   logic [COUNT_WIDTH-1:0] remaining;
   logic [COUNT_WIDTH-1:0] prev_count;
   logic                   gap;
   logic                   drain_hold;
   logic                   timer_clear;
   logic                   timer_done;

   // Quiet time is only meaningful while waiting; any buffer movement restarts it.
   assign timer_clear = (state != WTX_WAIT) || (buf_count != prev_count);

   wless_idle_timer #(
      .TIMER_WIDTH (TIMER_WIDTH),
      .DONE_VALUE  (END_WAITING_SEND_WLESS_DATA - 1)
   ) u_idle_timer (
      .internal_clk (internal_clk),
      .rst_n        (rst_n),
      .clear        (timer_clear),
      .done         (timer_done)
   );

   always_ff @(posedge internal_clk) begin
      if (!rst_n) begin
         state             <= WTX_IDLE;
         buf_rd            <= 1'b0;
         TX_use_node       <= 1'b0;
         data_to_uart_node <= '0;
         wtrans_active     <= 1'b0;
         aux_n             <= 1'b1;
         pkt_sent          <= '0;
         remaining         <= '0;
         prev_count        <= '0;
         gap               <= 1'b0;
         drain_hold        <= 1'b0;
      end else begin
         prev_count  <= buf_count;
         buf_rd      <= 1'b0;
         TX_use_node <= 1'b0;
         case (state)
            WTX_IDLE: begin
               if (enable && buf_count != '0) begin
                  state <= WTX_WAIT;
                  aux_n <= 1'b0;
               end
            end
            WTX_WAIT: begin
               if (!enable) begin
                  state <= WTX_IDLE;
                  aux_n <= 1'b1;
               end else if (buf_count >= PKT_LEN) begin
                  remaining     <= PKT_LEN;
                  state         <= WTX_LOAD;
                  wtrans_active <= 1'b1;
                  gap           <= 1'b0;
               end else if (timer_done) begin
                  remaining     <= buf_count;
                  state         <= WTX_LOAD;
                  wtrans_active <= 1'b1;
                  gap           <= 1'b0;
               end
            end
            WTX_LOAD: begin
               // An empty buffer with bytes still owed ends the packet short.
               if (remaining == '0 || (!gap && buf_count == '0)) begin
                  state      <= WTX_DRAIN;
                  drain_hold <= 1'b1;
               end else if (gap) begin
                  gap <= 1'b0;
               end else if (!TX_flag_node) begin
                  buf_rd            <= 1'b1;
                  TX_use_node       <= 1'b1;
                  data_to_uart_node <= buf_data;
                  remaining         <= remaining - 1'b1;
                  gap               <= 1'b1;
               end
            end
            WTX_DRAIN: begin
               // One hold cycle keeps completion from being sampled before the
               // node FIFO has seen the final write.
               if (drain_hold) begin
                  drain_hold <= 1'b0;
               end else if (TX_complete_node) begin
                  pkt_sent      <= pkt_sent + 16'd1;
                  wtrans_active <= 1'b0;
                  if (enable && buf_count != '0) begin
                     state <= WTX_WAIT;
                  end else begin
                     state <= WTX_IDLE;
                     aux_n <= 1'b1;
                  end
               end
            end
            default: begin
               state <= WTX_IDLE;
               aux_n <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wless_tx_scheduler.sv
// Scoreboard bench for wless_tx_scheduler: a queue model of the MCU buffer and
// node UART, expected bytes and packet sizes queued by stimulus, checked by a monitor.
module tb_wless_tx_scheduler;

   localparam int PKT   = 58;
   localparam int END_W = 31250;

   logic        internal_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        TX_flag_node = 1'b0;
   logic        TX_complete_node = 1'b1;
   logic [9:0]  buf_count = '0;
   logic [7:0]  buf_data = '0;
   logic        buf_rd;
   logic        TX_use_node;
   logic        wtrans_active;
   logic        aux_n;
   logic [7:0]  data_to_uart_node;
   logic [15:0] pkt_sent;

   int total = 0;
   int bad   = 0;

   byte unsigned bq[$];
   byte unsigned src_q[$];
   byte unsigned exp_q[$];
   int           pkt_q[$];
   bit           flush = 1'b0;

   int cyc = 0;
   int last_wr_cyc = 0;
   int rise_cyc = 0;
   int first_strobe_cyc = 0;
   int last_strobe_cyc = 0;
   int node_busy = 0;

   wless_tx_scheduler dut (
      .internal_clk      (internal_clk),
      .rst_n             (rst_n),
      .enable            (enable),
      .buf_count         (buf_count),
      .buf_data          (buf_data),
      .buf_rd            (buf_rd),
      .data_to_uart_node (data_to_uart_node),
      .TX_use_node       (TX_use_node),
      .TX_flag_node      (TX_flag_node),
      .TX_complete_node  (TX_complete_node),
      .wtrans_active     (wtrans_active),
      .aux_n             (aux_n),
      .pkt_sent          (pkt_sent)
   );

   always #5 internal_clk = ~internal_clk;

   always @(posedge internal_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // MCU buffer (one write per cycle from src_q) and node UART busy model.
   always @(negedge internal_clk) begin
      if (flush) begin
         bq.delete();
      end else begin
         if (buf_rd && bq.size() > 0) void'(bq.pop_front());
         if (src_q.size() > 0) begin
            bq.push_back(src_q.pop_front());
            last_wr_cyc = cyc;
         end
      end
      if (TX_use_node) node_busy = 8;
      else if (node_busy > 0) node_busy--;
      TX_complete_node = (node_busy == 0);
      buf_count = 10'(bq.size());
      buf_data  = (bq.size() > 0) ? bq[0] : 8'h00;
   end

   // Monitor: compares every strobe and every packet completion to the queues.
   logic        prev_strobe = 1'b0;
   logic        prev_flag = 1'b0;
   logic        prev_wt = 1'b0;
   logic [15:0] last_pkt = '0;
   int          cur_cnt = 0;

   always @(negedge internal_clk) begin
      if (!rst_n) begin
         cur_cnt     = 0;
         last_pkt    = '0;
         prev_strobe = 1'b0;
         prev_wt     = 1'b0;
      end else begin
         if (buf_rd || TX_use_node) begin
            chk("rd_eq_use", buf_rd, TX_use_node);
            chk("no_back_to_back", prev_strobe, 0);
            chk("stall_no_write", prev_flag, 0);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_strobe actual=%0d required=none", data_to_uart_node);
            end else begin
               chk("tx_data", data_to_uart_node, exp_q.pop_front());
            end
            if (cur_cnt == 0) first_strobe_cyc = cyc;
            last_strobe_cyc = cyc;
            cur_cnt++;
         end
         if (wtrans_active && !prev_wt) rise_cyc = cyc;
         if (pkt_sent != last_pkt) begin
            chk("pkt_inc", pkt_sent, last_pkt + 16'd1);
            if (pkt_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pkt actual=%0d required=none", cur_cnt);
            end else begin
               chk("pkt_len", cur_cnt, pkt_q.pop_front());
            end
            cur_cnt  = 0;
            last_pkt = pkt_sent;
         end
         prev_strobe = TX_use_node;
         prev_wt     = wtrans_active;
      end
      prev_flag = TX_flag_node;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge internal_clk);
      #1;
   endtask

   task automatic write_bytes(input int n, input int base, input int n_exp);
      for (int i = 0; i < n; i++) begin
         src_q.push_back(8'(base + i));
         if (i < n_exp) exp_q.push_back(8'(base + i));
      end
   endtask

   task automatic wait_pkt(input int n, input int budget);
      int k = 0;
      while (pkt_sent != 16'(n) && k < budget) begin
         @(posedge internal_clk);
         k++;
      end
      #1;
      chk("pkt_wait", pkt_sent, n);
   endtask

   task automatic wait_strobes(input int n, input int budget);
      int seen = 0;
      int k = 0;
      while (seen < n && k < budget) begin
         @(negedge internal_clk);
         if (TX_use_node) seen++;
         k++;
      end
      chk("strobe_wait", seen, n);
      tick(1);
   endtask

   initial begin
      // reset values
      tick(3);
      @(negedge internal_clk);
      chk("rst_buf_rd", buf_rd, 0);
      chk("rst_tx_use", TX_use_node, 0);
      chk("rst_data", data_to_uart_node, 0);
      chk("rst_wtrans", wtrans_active, 0);
      chk("rst_aux_n", aux_n, 1);
      chk("rst_pkt_sent", pkt_sent, 0);
      tick(1);
      rst_n  = 1'b1;
      enable = 1'b1;

      // full packet 0x00..0x39, no back-pressure
      write_bytes(PKT, 8'h00, PKT);
      pkt_q.push_back(PKT);
      wait_pkt(1, 2000);
      chk("full_span", last_strobe_cyc - first_strobe_cyc, 2 * PKT - 2);
      tick(3);
      chk("full_aux_n", aux_n, 1);
      chk("full_wtrans", wtrans_active, 0);
      chk("full_pkt_sent", pkt_sent, 1);

      // short packet after quiet timeout
      write_bytes(5, 8'h40, 5);
      pkt_q.push_back(5);
      wait_pkt(2, 40000);
      chk("quiet_cycles", rise_cyc - last_wr_cyc - 1, END_W);
      chk("quiet_first_strobe", first_strobe_cyc - last_wr_cyc, END_W + 2);
      tick(3);
      chk("short_aux_n", aux_n, 1);

      // 130 bytes -> 58, 58, then 14 after timeout
      write_bytes(130, 8'h80, 130);
      pkt_q.push_back(PKT);
      pkt_q.push_back(PKT);
      pkt_q.push_back(14);
      wait_pkt(5, 40000);
      tick(3);
      chk("multi_buf_empty", buf_count, 0);
      chk("multi_aux_n", aux_n, 1);

      // back-pressure stall mid-packet
      write_bytes(PKT, 8'h10, PKT);
      pkt_q.push_back(PKT);
      wait_strobes(20, 500);
      TX_flag_node = 1'b1;
      tick(20);
      TX_flag_node = 1'b0;
      wait_pkt(6, 2000);

      // enable dropped during LOAD: packet still completes, then IDLE
      write_bytes(60, 8'hA0, PKT);
      pkt_q.push_back(PKT);
      wait_strobes(10, 500);
      enable = 1'b0;
      wait_pkt(7, 2000);
      tick(3);
      chk("drop_aux_n", aux_n, 1);
      chk("drop_wtrans", wtrans_active, 0);
      chk("drop_left", buf_count, 2);

      // enable dropped during WAIT: back to IDLE, nothing popped
      enable = 1'b1;
      tick(3);
      chk("wait_aux_n", aux_n, 0);
      enable = 1'b0;
      tick(3);
      chk("wait_drop_aux_n", aux_n, 1);
      chk("wait_drop_left", buf_count, 2);
      flush = 1'b1;
      tick(2);
      flush = 1'b0;

      // reset mid-LOAD
      enable = 1'b1;
      write_bytes(PKT, 8'h55, PKT);
      wait_strobes(5, 500);
      rst_n  = 1'b0;
      enable = 1'b0;
      exp_q.delete();
      pkt_q.delete();
      @(posedge internal_clk);
      @(negedge internal_clk);
      chk("mid_rst_buf_rd", buf_rd, 0);
      chk("mid_rst_tx_use", TX_use_node, 0);
      chk("mid_rst_data", data_to_uart_node, 0);
      chk("mid_rst_wtrans", wtrans_active, 0);
      chk("mid_rst_aux_n", aux_n, 1);
      chk("mid_rst_pkt_sent", pkt_sent, 0);
      flush = 1'b1;
      tick(2);
      flush = 1'b0;
      rst_n = 1'b1;
      tick(5);
      chk("post_rst_no_strobe", TX_use_node, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
